// File: rtl/pipe_hazard_sched_if.sv
// rtl/pipe_hazard_sched_if.sv - hazard scheduler signal bundle between pipeline core and scheduler
interface pipe_hazard_sched_if #(
  parameter int CNT_W = 16
);
  // Core-side status
  logic             M_StartE;
  logic             MDone;
  logic             MemtoRegE;
  logic             RegWriteE;
  logic [3:0]       WA3E;
  logic [3:0]       RA1D;
  logic [3:0]       RA2D;
  logic             PCSrcE;

  // Scheduler-side controls and status
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             MStart;
  logic [1:0]       mc_state;
  logic             mc_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output M_StartE, MDone, MemtoRegE, RegWriteE, WA3E, RA1D, RA2D, PCSrcE,
    input  StallF, StallD, StallE, FlushD, FlushE, MStart, mc_state, mc_timeout, stall_count
  );

  modport slave (
    input  M_StartE, MDone, MemtoRegE, RegWriteE, WA3E, RA1D, RA2D, PCSrcE,
    output StallF, StallD, StallE, FlushD, FlushE, MStart, mc_state, mc_timeout, stall_count
  );
endinterface

// File: rtl/pipe_hazard_sched.sv
// rtl/pipe_hazard_sched.sv - pipeline stall/flush scheduler with multi-cycle launch and watchdog
module pipe_hazard_sched #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_p,
  pipe_hazard_sched_if.slave  hz_io
);

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RUN  = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  localparam logic [15:0]      WDOG_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0]      WDOG_ONE  = 16'd1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mc_state_e        state_q, state_d;
  logic [15:0]      wdog_q, wdog_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic stall_f, stall_d, stall_e, flush_d, flush_e, m_start;
  logic load_use;
  logic hz_stall, hz_flush_d, hz_flush_e;

  // Load-use: a load in E feeding either source operand of the instruction in D.
  assign load_use = hz_io.MemtoRegE & hz_io.RegWriteE &
                    ((hz_io.WA3E == hz_io.RA1D) | (hz_io.WA3E == hz_io.RA2D));

  // A taken branch squashes the dependent instruction anyway, so it wins over the load-use stall.
  assign hz_stall   = load_use & ~hz_io.PCSrcE;
  assign hz_flush_d = hz_io.PCSrcE;
  assign hz_flush_e = hz_io.PCSrcE | load_use;

  // Next-state and combinational pipeline controls; everything is quiet while reset is held.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    m_start   = 1'b0;
    state_d   = state_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (!rst_p) begin
      case (state_q)
        MC_IDLE: begin
          if (hz_io.M_StartE) begin
            // Launch cycle: freeze F/D/E; a coincident branch still flushes.
            m_start = 1'b1;
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_d = hz_io.PCSrcE;
            flush_e = hz_io.PCSrcE;
            state_d = MC_RUN;
            wdog_d  = '0;
          end else begin
            stall_f = hz_stall;
            stall_d = hz_stall;
            flush_d = hz_flush_d;
            flush_e = hz_flush_e;
          end
        end
        MC_RUN: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          wdog_d  = wdog_q + WDOG_ONE;
          if (hz_io.MDone) begin
            state_d = MC_DONE;
          end else if (wdog_q == WDOG_LAST) begin
            timeout_d = 1'b1;
            state_d   = MC_IDLE;
          end
        end
        MC_DONE: begin
          // The finished op is still in E this cycle; M_StartE must not relaunch it.
          stall_f = hz_stall;
          stall_d = hz_stall;
          flush_d = hz_flush_d;
          flush_e = hz_flush_e;
          state_d = MC_IDLE;
        end
        default: begin
          state_d = MC_IDLE;
        end
      endcase
    end
  end

  // Saturating count of front-end stall cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_f && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State, watchdog, sticky timeout and stall counter registers.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q   <= MC_IDLE;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign hz_io.StallF      = stall_f;
  assign hz_io.StallD      = stall_d;
  assign hz_io.StallE      = stall_e;
  assign hz_io.FlushD      = flush_d;
  assign hz_io.FlushE      = flush_e;
  assign hz_io.MStart      = m_start;
  assign hz_io.mc_state    = state_q;
  assign hz_io.mc_timeout  = timeout_q;
  assign hz_io.stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// tb/tb_pipe_hazard_sched.sv - self-checking bench for pipe_hazard_sched
module tb_pipe_hazard_sched;

  localparam int TO = 8;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_p = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_sched_if #(.CNT_W(CW)) hz();

  pipe_hazard_sched #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .hz_io (hz)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 idle, 1 running, 2 done; m_run counts RUN cycles spent.
  int m_state, m_run, m_cnt;
  bit m_to;

  // {StallF, StallD, StallE, FlushD, FlushE, MStart}
  function automatic logic [5:0] model_outs();
    logic lu;
    lu = hz.MemtoRegE && hz.RegWriteE && (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);
    if (rst_p) return 6'b000000;
    if (m_state == 1) return 6'b111000;
    if (m_state == 0 && hz.M_StartE) return {3'b111, hz.PCSrcE, hz.PCSrcE, 1'b1};
    if (hz.PCSrcE) return 6'b000110;
    if (lu) return 6'b110010;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] dut_outs();
    return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.MStart};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_run   = 0;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  // Advance model by one clock using the inputs currently applied, then cross the edge.
  task automatic tick();
    logic [5:0] e;
    e = model_outs();
    if (e[5] && m_cnt < (1 << CW) - 1) m_cnt++;
    case (m_state)
      0: if (hz.M_StartE) begin m_state = 1; m_run = 0; end
      1: begin
        m_run++;
        if (hz.MDone) m_state = 2;
        else if (m_run == TO) begin m_to = 1'b1; m_state = 0; end
      end
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ms, input logic md, input logic mr, input logic rw,
                        input logic [3:0] wa, input logic [3:0] r1, input logic [3:0] r2,
                        input logic pc);
    hz.M_StartE  = ms;
    hz.MDone     = md;
    hz.MemtoRegE = mr;
    hz.RegWriteE = rw;
    hz.WA3E      = wa;
    hz.RA1D      = r1;
    hz.RA2D      = r2;
    hz.PCSrcE    = pc;
    #1;
  endtask

  task automatic do_reset();
    rst_p = 1'b1;
    set_in(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst_p = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (dut_outs() !== 6'b000000) begin n_err++; $display("FAIL reset_outs: got %b expected %b", dut_outs(), 6'b000000); end
    n_vec++; if (hz.mc_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", hz.mc_state); end
    n_vec++; if (hz.mc_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", hz.mc_timeout); end
    n_vec++; if (hz.stall_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", hz.stall_count); end
  endtask

  task automatic test_multicycle();
    logic [5:0] exp_o [7] = '{6'b111001, 6'b111000, 6'b111000, 6'b111000, 6'b111000, 6'b000000, 6'b000000};
    int         ms_t  [7] = '{1, 1, 1, 1, 1, 1, 0};
    int         md_t  [7] = '{0, 0, 0, 0, 1, 0, 0};
    int         st_t  [7] = '{0, 1, 1, 1, 1, 2, 0};
    int n_ms, n_st;
    n_ms = 0;
    n_st = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_in(ms_t[i][0], md_t[i][0], 0, 0, 4'd0, 4'd0, 4'd0, 0);
      n_vec++; if (hz.mc_state !== st_t[i][1:0]) begin n_err++; $display("FAIL mc_seq_state[%0d]: got %0d expected %0d", i, hz.mc_state, st_t[i]); end
      n_vec++; if (dut_outs() !== exp_o[i]) begin n_err++; $display("FAIL mc_seq_outs[%0d]: got %b expected %b", i, dut_outs(), exp_o[i]); end
      if (hz.MStart === 1'b1) n_ms++;
      if (hz.StallF === 1'b1) n_st++;
      tick();
    end
    n_vec++; if (n_ms != 1) begin n_err++; $display("FAIL mc_mstart_cycles: got %0d expected 1", n_ms); end
    n_vec++; if (n_st != 5) begin n_err++; $display("FAIL mc_stall_cycles: got %0d expected 5", n_st); end
    n_vec++; if (hz.stall_count !== 6'd5) begin n_err++; $display("FAIL mc_stall_count: got %0d expected 5", hz.stall_count); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(0, 0, 1, 1, 4'd3, 4'd0, 4'd3, 0);
    n_vec++; if (dut_outs() !== 6'b110010) begin n_err++; $display("FAIL lu_ra2: got %b expected %b", dut_outs(), 6'b110010); end
    tick();
    set_in(0, 0, 1, 1, 4'd3, 4'd4, 4'd4, 0);
    n_vec++; if (dut_outs() !== 6'b000000) begin n_err++; $display("FAIL lu_nomatch: got %b expected %b", dut_outs(), 6'b000000); end
    tick();
    set_in(0, 0, 1, 1, 4'd3, 4'd3, 4'd4, 0);
    n_vec++; if (dut_outs() !== 6'b110010) begin n_err++; $display("FAIL lu_ra1: got %b expected %b", dut_outs(), 6'b110010); end
    tick();
    set_in(0, 0, 1, 0, 4'd3, 4'd3, 4'd3, 0);
    n_vec++; if (dut_outs() !== 6'b000000) begin n_err++; $display("FAIL lu_nowrite: got %b expected %b", dut_outs(), 6'b000000); end
    tick();
    n_vec++; if (hz.stall_count !== 6'd2) begin n_err++; $display("FAIL lu_count: got %0d expected 2", hz.stall_count); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    set_in(0, 0, 1, 1, 4'd3, 4'd3, 4'd3, 1);
    n_vec++; if (dut_outs() !== 6'b000110) begin n_err++; $display("FAIL br_over_lu: got %b expected %b", dut_outs(), 6'b000110); end
    tick();
    set_in(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1);
    n_vec++; if (dut_outs() !== 6'b111111) begin n_err++; $display("FAIL br_with_launch: got %b expected %b", dut_outs(), 6'b111111); end
    tick();
    set_in(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1);
    n_vec++; if (dut_outs() !== 6'b111000) begin n_err++; $display("FAIL br_in_run: got %b expected %b", dut_outs(), 6'b111000); end
  endtask

  task automatic test_timeout();
    do_reset();
    set_in(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    tick();
    for (int i = 1; i <= TO; i++) begin
      set_in(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
      n_vec++; if (hz.mc_state !== 2'd1 || hz.mc_timeout !== 1'b0) begin n_err++; $display("FAIL to_run[%0d]: got state %0d flag %b expected state 1 flag 0", i, hz.mc_state, hz.mc_timeout); end
      tick();
    end
    set_in(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    n_vec++; if (hz.mc_state !== 2'd0) begin n_err++; $display("FAIL to_state: got %0d expected 0", hz.mc_state); end
    n_vec++; if (hz.mc_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b expected 1", hz.mc_timeout); end
    n_vec++; if (hz.stall_count !== 6'(TO + 1)) begin n_err++; $display("FAIL to_count: got %0d expected %0d", hz.stall_count, TO + 1); end
    set_in(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    n_vec++; if (dut_outs() !== 6'b000000) begin n_err++; $display("FAIL to_late_outs: got %b expected %b", dut_outs(), 6'b000000); end
    tick();
    set_in(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    n_vec++; if (hz.mc_state !== 2'd0 || hz.mc_timeout !== 1'b1) begin n_err++; $display("FAIL to_late_mdone: got state %0d flag %b expected state 0 flag 1", hz.mc_state, hz.mc_timeout); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    tick();
    tick();
    n_vec++; if (hz.mc_state !== 2'd1 || dut_outs() !== 6'b111000) begin n_err++; $display("FAIL ar_run2: got state %0d outs %b expected state 1 outs 111000", hz.mc_state, dut_outs()); end
    #1;
    rst_p = 1'b1;
    model_reset();
    #1;
    n_vec++; if (hz.mc_state !== 2'd0) begin n_err++; $display("FAIL ar_state: got %0d expected 0", hz.mc_state); end
    n_vec++; if (dut_outs() !== 6'b000000) begin n_err++; $display("FAIL ar_outs: got %b expected %b", dut_outs(), 6'b000000); end
    rst_p = 1'b0;
    #1;
    n_vec++; if (dut_outs() !== model_outs()) begin n_err++; $display("FAIL ar_relaunch: got %b expected %b", dut_outs(), model_outs()); end
    tick();
    set_in(1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    n_vec++; if (hz.mc_state !== 2'd1) begin n_err++; $display("FAIL ar_run_again: got %0d expected 1", hz.mc_state); end
    tick();
    n_vec++; if (hz.mc_state !== 2'd2) begin n_err++; $display("FAIL ar_done: got %0d expected 2", hz.mc_state); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(0, 0, 1, 1, 4'd7, 4'd7, 4'd1, 0);
    for (int i = 0; i < 70; i++) tick();
    n_vec++; if (hz.stall_count !== 6'd63) begin n_err++; $display("FAIL sat_count: got %0d expected 63", hz.stall_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      set_in($urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
             1'($urandom), 1'($urandom),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             $urandom_range(0, 5) == 0);
      n_vec++; if (dut_outs() !== model_outs()) begin n_err++; $display("FAIL rnd_outs[%0d]: got %b expected %b", i, dut_outs(), model_outs()); end
      n_vec++; if (hz.mc_state !== 2'(m_state)) begin n_err++; $display("FAIL rnd_state[%0d]: got %0d expected %0d", i, hz.mc_state, m_state); end
      n_vec++; if (hz.mc_timeout !== m_to) begin n_err++; $display("FAIL rnd_timeout[%0d]: got %b expected %b", i, hz.mc_timeout, m_to); end
      n_vec++; if (hz.stall_count !== CW'(m_cnt)) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, hz.stall_count, m_cnt); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_multicycle();
    test_load_use();
    test_branch_priority();
    test_timeout();
    test_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
